imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory. It accepts a length-prefixed byte stream over a valid/ready handshake and packs each group of four bytes, little-endian, into a 32-bit word. Each word is written through a single-cycle write strobe to consecutive word-aligned addresses. The block holds the core in reset (`cpu_hold`) until a load completes cleanly, and it sits between the host byte source (UART/JTAG bridge) and the write port of the instruction memory.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written; must be 4-byte aligned.
- `MAX_WORDS`, default 64: largest accepted word count, matching the instruction memory depth.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a load session; ignored while `busy`.
- `rx_valid`  in  1  byte-source valid.
- `rx_data`  in  8  byte from the source.
- `rx_ready`  out  1  loader can accept a byte this cycle.
- `we`  out  1  instruction-memory write strobe, one cycle per word.
- `A`  out  32  byte address of the write, word-aligned.
- `WD`  out  32  write data.
- `cpu_hold`  out  1  holds the core in reset while high.
- `busy`  out  1  a session is in progress.
- `done`  out  1  last session completed without error.
- `err`  out  1  last session aborted.

## Operation
- A byte is accepted on a rising edge when `rx_valid && rx_ready`. Holding a byte with `rx_valid=1, rx_ready=0` is legal; it is not consumed.
- FSM states are IDLE, LEN0, LEN1, DATA, WRITE, CKSUM (only with the macro), DONE, and ERR.
- IDLE/DONE/ERR → LEN0 on `start`. Entering LEN0 clears `done`/`err`, sets `cpu_hold=1` and `busy=1`, and zeroes the word index, byte index, and checksum accumulator.
- LEN0 accepts the count low byte. LEN1 accepts the count high byte, giving a 16-bit count N.
  - N=0 → DONE.
  - N>MAX_WORDS → ERR.
  - Otherwise → DATA.
- DATA accepts 4 bytes: byte0 → WD[7:0] … byte3 → WD[31:24]. After the 4th byte, go to WRITE.
- WRITE lasts one cycle with `rx_ready=0` and `we=1`.
  - `A = BASE_ADDR + 4*index` (32-bit, wraps modulo 2^32); `WD` is the packed word.
  - Then index increments. If index==N, go to CKSUM (with macro) or DONE; otherwise go to DATA.
- DONE: `done=1`, `busy=0`, `cpu_hold=0`. These hold until the next `start`.
- ERR: `err=1`, `busy=0`, `cpu_hold=1`. Words already written are not rolled back.
- `start` while `busy` is ignored. Bytes offered in IDLE/DONE/ERR are not consumed (`rx_ready=0`).
- `rst` assertion at any point, including mid-word, aborts immediately. Partial words are discarded and the FSM returns to IDLE.

## Timing
- Reset values:
  - `rx_ready=0`, `we=0`, `A=BASE_ADDR`, `WD=0`
  - `cpu_hold=1`, `busy=0`, `done=0`, `err=0`
- `rx_ready` is a registered decode of the state: high in LEN0, LEN1, DATA, and CKSUM.
- Write latency: `we` rises the cycle after the 4th byte of a word is accepted. `A` and `WD` are valid in that same cycle and hold until the next write.
- Minimum session length is N×5 + 2 cycles of accepted traffic, plus 1 cycle if CKSUM is compiled in.
- `done`/`err` assert the cycle after the final transition. In the same cycle, `cpu_hold` deasserts on success.
- `start` together with `rx_valid` in the same cycle: the byte is not consumed, and LEN0 starts the following cycle.

## Configuration
- Macro `IMEM_LOADER_CKSUM_EN`.
- Defined:
  - After the last word, CKSUM accepts one byte.
  - The expected value is the 8-bit modulo-256 sum of all data bytes (length bytes excluded).
  - Match → DONE. Mismatch → ERR (`cpu_hold` stays 1).
  - With N=0 the checksum byte is still required, and its expected value is 0x00.
- Undefined:
  - No CKSUM state and no accumulator logic; the session ends after the last WRITE.
  - A following byte is not consumed.

## Test plan
- **Two-word load:** reset, `start`, then stream 02 00 03 A3 C4 FF 23 A4 64 00 with checksum byte 94 if the macro is enabled. Required: `we` pulses A=0x0/WD=FFC4A303 and A=0x4/WD=0064A423; then `done=1`, `cpu_hold=0`.
- **Back-pressure and gaps:** same stream with `rx_valid` toggled every other cycle. Required: identical writes, no byte lost or duplicated, and `rx_ready=0` during both WRITE cycles.
- **Oversize count:** stream 41 00 (N=65) with MAX_WORDS=64. Required: `err=1`, no `we` pulse, `cpu_hold=1`, and later bytes are not consumed.
- **Zero count:** stream 00 00 (plus 00 with the macro). Required: `done=1`, no writes.
- **Mid-word reset:** assert `rst` after 2 data bytes, release, then rerun the two-word load. Required: all outputs at reset values during reset, and the rerun produces exactly the first scenario's writes.
- **Checksum mismatch (macro only):** two-word stream with checksum byte 95. Required: both writes occur, then `err=1`, `done=0`, `cpu_hold=1`.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed byte stream -> little-endian 32-bit word writes.
// Optional trailing checksum byte when IMEM_LOADER_CKSUM_EN is defined.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE,
`ifdef IMEM_LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE, S_ERR
  } state_t;

  state_t      state;
  logic [7:0]  n_lo;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]  cksum;
`endif

  logic        accept;
  logic [15:0] n_next;
  logic [15:0] idx_next;

  assign accept   = rx_valid && rx_ready;
  assign n_next   = {rx_data, n_lo};
  assign idx_next = word_idx + 16'd1;

  // Length and partial-word holding registers; always rewritten before use, so no reset.
  always_ff @(posedge clk) begin
    if (accept && state == S_LEN0) n_lo <= rx_data;
    if (accept && state == S_LEN1) n_words <= n_next;
    if (accept && state == S_DATA) begin
      case (byte_idx)
        2'd0:    word_buf[7:0]   <= rx_data;
        2'd1:    word_buf[15:8]  <= rx_data;
        2'd2:    word_buf[23:16] <= rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      rx_ready <= 1'b0;
      we       <= 1'b0;
      A        <= BASE_ADDR;
      WD       <= '0;
      cpu_hold <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      word_idx <= '0;
      byte_idx <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cksum    <= '0;
`endif
    end else begin
      we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_LEN0;
            rx_ready <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
            word_idx <= '0;
            byte_idx <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum    <= '0;
`endif
          end
        end
        S_LEN0: if (accept) state <= S_LEN1;
        S_LEN1: begin
          if (accept) begin
            if (n_next == 16'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
              state <= S_CKSUM;
`else
              state    <= S_DONE;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
`endif
            end else if (n_next > MAX_N) begin
              state    <= S_ERR;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum    <= cksum + rx_data;
`endif
            // Fourth byte goes straight into WD so the write lands one cycle later.
            if (byte_idx == 2'd3) begin
              state    <= S_WRITE;
              rx_ready <= 1'b0;
              we       <= 1'b1;
              A        <= BASE_ADDR + {14'd0, word_idx, 2'b00};
              WD       <= {rx_data, word_buf};
            end
          end
        end
        S_WRITE: begin
          word_idx <= idx_next;
          if (idx_next == n_words) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state    <= S_CKSUM;
            rx_ready <= 1'b1;
`else
            state    <= S_DONE;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
`endif
          end else begin
            state    <= S_DATA;
            rx_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM: begin
          if (accept) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            if (rx_data == cksum) begin
              state    <= S_DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios plus random sessions checked against a stream-level model.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, we, cpu_hold, busy, done, err;
  logic [31:0] A, WD;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .we(we), .A(A), .WD(WD), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Monitor: everything observed on the falling edge, away from the active edge.
  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  int acc_cnt = 0;
  int rdy_we_viol = 0;
  always @(negedge clk) begin
    if (rx_valid && rx_ready) acc_cnt++;
    if (we) begin
      got_a.push_back(A);
      got_d.push_back(WD);
      if (rx_ready) rdy_we_viol++;
    end
  end

  // Reference model results
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  int exp_consumed;
  bit exp_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [7:0] s[$]);
    int n;
    logic [7:0] sum;
    exp_a.delete();
    exp_d.delete();
    n = int'(s[0]) + 256 * int'(s[1]);
    exp_consumed = 2;
    exp_done = 1'b0;
    if (n <= MAXW) begin
      sum = 8'h00;
      for (int w = 0; w < n; w++) begin
        int b;
        b = 2 + 4 * w;
        exp_a.push_back(BASE + 32'(4 * w));
        exp_d.push_back({s[b+3], s[b+2], s[b+1], s[b]});
        sum = sum + s[b] + s[b+1] + s[b+2] + s[b+3];
      end
      exp_consumed = 2 + 4 * n;
`ifdef IMEM_LOADER_CKSUM_EN
      exp_done = (s[exp_consumed] == sum);
      exp_consumed++;
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  // Pulse start with the first byte already offered; that byte must not be taken in the start cycle.
  task automatic start_and_drive(input logic [7:0] s[$], input bit gaps);
    int i = 0;
    int cyc = 0;
    bit tog = 1'b1;
    bit acc;
    @(posedge clk); #1;
    start = 1'b1; rx_valid = 1'b1; rx_data = s[0];
    @(posedge clk); #1;
    start = 1'b0;
    while (i < s.size() && cyc < 3 * s.size() + 40) begin
      rx_data  = s[i];
      rx_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      @(negedge clk);
      acc = rx_valid && rx_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_session(input string name, input logic [7:0] s[$], input bit gaps);
    int a0, w0, v0, ngot, nchk;
    model(s);
    a0 = acc_cnt; w0 = got_a.size(); v0 = rdy_we_viol;
    start_and_drive(s, gaps);
    for (int k = 0; k < 20 && busy; k++) @(posedge clk);
    @(negedge clk);
    chk({name, " consumed"}, 32'(acc_cnt - a0), 32'(exp_consumed));
    chk({name, " busy"}, {31'd0, busy}, 32'd0);
    chk({name, " done"}, {31'd0, done}, {31'd0, exp_done});
    chk({name, " err"}, {31'd0, err}, {31'd0, !exp_done});
    chk({name, " cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
    chk({name, " rdy_in_write"}, 32'(rdy_we_viol - v0), 32'd0);
    ngot = got_a.size() - w0;
    chk({name, " nwrites"}, 32'(ngot), 32'(exp_a.size()));
    nchk = (ngot < exp_a.size()) ? ngot : exp_a.size();
    for (int k = 0; k < nchk; k++) begin
      chk($sformatf("%s A[%0d]", name, k), got_a[w0+k], exp_a[k]);
      chk($sformatf("%s WD[%0d]", name, k), got_d[w0+k], exp_d[k]);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, " rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({name, " we"}, {31'd0, we}, 32'd0);
    chk({name, " A"}, A, BASE);
    chk({name, " WD"}, WD, 32'd0);
    chk({name, " cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    chk({name, " busy"}, {31'd0, busy}, 32'd0);
    chk({name, " done"}, {31'd0, done}, 32'd0);
    chk({name, " err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] two[$];
    logic [7:0] s[$];
    logic [7:0] sum;
    int n;

    two = '{8'h02, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h23, 8'hA4, 8'h64, 8'h00};
`ifdef IMEM_LOADER_CKSUM_EN
    two.push_back(8'h94);
`endif
    two.push_back(8'h5A);
    two.push_back(8'hA5);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    run_session("two_word", two, 1'b0);
    run_session("two_word_gaps", two, 1'b1);

    s = '{8'h41, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_session("oversize", s, 1'b0);

    s = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CKSUM_EN
    s.push_back(8'h00);
`endif
    s.push_back(8'h77);
    run_session("zero", s, 1'b1);

    // Exactly MAX_WORDS words is accepted
    s = '{8'h40, 8'h00};
    sum = 8'h00;
    for (int k = 0; k < 4 * MAXW; k++) begin
      s.push_back(8'($urandom));
      sum = sum + s[s.size()-1];
    end
`ifdef IMEM_LOADER_CKSUM_EN
    s.push_back(sum);
`endif
    s.push_back(8'h01);
    run_session("max_words", s, 1'b0);

`ifdef IMEM_LOADER_CKSUM_EN
    s = two;
    s[10] = 8'h95;
    run_session("cksum_bad", s, 1'b0);
`endif

    // Mid-word reset, then a clean rerun
    s = '{8'h02, 8'h00, 8'h03, 8'hA3};
    start_and_drive(s, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midword_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    run_session("rerun", two, 1'b0);

    // Random sessions
    for (int r = 0; r < 8; r++) begin
      n = (r == 3) ? 65 + $urandom_range(0, 200) : $urandom_range(0, 6);
      s.delete();
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      sum = 8'h00;
      if (n <= MAXW) begin
        for (int k = 0; k < 4 * n; k++) begin
          s.push_back(8'($urandom));
          sum = sum + s[s.size()-1];
        end
`ifdef IMEM_LOADER_CKSUM_EN
        s.push_back(($urandom_range(0, 3) == 0) ? sum + 8'd1 : sum);
`endif
      end
      s.push_back(8'($urandom));
      s.push_back(8'($urandom));
      run_session($sformatf("rand%0d", r), s, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
